station_scheduler: RTL
======================

Name: station_scheduler

Overview:
- Control block for a bank of integer reservation stations.
- Allocates a free station to each instruction issued by the decode stage.
- Arbitrates the single common result bus among stations holding ready results, using round-robin.
- Registers the granted result onto the bus and releases the granted station.
- Sits between decode/issue and the station bank. The registered bus output feeds the bus inputs of every station.

Parameters:
- SIZE, 32, data width of operands and results.
- STATION_COUNT, 4, number of stations managed (2..16).
- STATION_INDEX_SIZE, $clog2(STATION_COUNT), width of a station tag.

Ports:
- clock  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all in-flight work (branch mispredict).
- issue_valid  input  1  decode has an instruction to place.
- issue_ready  output  1  a station is free; the handshake completes when issue_valid && issue_ready.
- issue_station  output  STATION_INDEX_SIZE  tag of the station allocated this cycle.
- station_load  output  STATION_COUNT  one-hot load strobe to the stations.
- station_set_unoccupied  output  STATION_COUNT  release strobes to the stations.
- station_occupied  input  STATION_COUNT  occupied flag from each station.
- station_result_ready  input  STATION_COUNT  result-ready flag from each station.
- station_result  input  STATION_COUNT*SIZE  flattened results; station i occupies bits [i*SIZE +: SIZE].
- bus_asserted  output  1  result bus valid.
- bus_source  output  STATION_INDEX_SIZE  tag of the broadcasting station.
- bus_value  output  SIZE  broadcast result.

Behaviour:
- Reset (reset, synchronous, active-high; clock clock):
  - Registered outputs: bus_asserted=0, bus_source=0, bus_value=0; round-robin pointer rr_ptr=0.
  - While reset is high, issue_ready, station_load and station_set_unoccupied are forced to 0.
  - Reset asserted mid-broadcast drops bus_asserted at the next edge.
- Allocation (combinational, zero latency):
  - free = ~station_occupied.
  - issue_ready = |free && !flush.
  - issue_station = lowest-index free station.
  - station_load[issue_station] = issue_valid && issue_ready. All other load bits are 0; at most one bit is ever set.
  - issue_station is don't-care when issue_ready=0. It is driven to 0 in that case.
- Result arbitration (combinational grant):
  - cand = station_occupied & station_result_ready.
  - Grant goes to the first set bit of cand searching from rr_ptr upward, wrapping modulo STATION_COUNT.
  - When cand=0, no grant is made.
- Grant consequences:
  - The grant cycle asserts station_set_unoccupied[g]=1.
  - At the next edge:
    - bus_asserted<=1, bus_source<=g, bus_value<=station_result[g].
    - rr_ptr<=(g+1) mod STATION_COUNT, wrapping from STATION_COUNT-1 to 0.
  - With no grant: bus_asserted<=0, and bus_source/bus_value hold their values.
  - Latency: ready-to-bus is 1 cycle. A station released in cycle N is reported free from cycle N+1 and can be reallocated in N+1.
- Simultaneous events:
  - A station granted this cycle is still occupied, so it is never allocated in the same cycle.
  - A station being loaded this cycle reads unoccupied, so it is never granted.
  - With several candidates, one grant per cycle. The others wait, and fairness comes from rr_ptr.
- Flush (flush=1):
  - station_set_unoccupied = station_occupied (all occupied stations released).
  - Allocation and grant are suppressed.
  - bus_asserted<=0 at the next edge; rr_ptr<=0.
  - flush has priority over issue and grant; reset has priority over flush.
- All stations occupied: issue_ready=0 until a release takes effect.

Test Plan:
- Reset, then issue_valid=1 with occupied=4'b0000 -> issue_ready=1, issue_station=0, station_load=4'b0001; no bus activity.
- occupied=4'b1011 with issue_valid=1 -> issue_station=2, station_load=4'b0100. With occupied=4'b1111 -> issue_ready=0, station_load=0.
- Station 1 occupied and ready with result 32'hDEADBEEF -> set_unoccupied=4'b0010 that cycle. Next cycle: bus_asserted=1, bus_source=1, bus_value=32'hDEADBEEF, rr_ptr=2.
- Stations 0, 1 and 3 all ready, held for 3 cycles, starting from rr_ptr=2 -> grants 3, 0, 1 in order, then bus_asserted=0 once cand=0.
- A station is granted while issue_valid=1 with only that station appearing in the grant; occupied=4'b1111 -> no allocation that cycle. Next cycle occupied drops -> issue_station=the granted index.
- flush with occupied=4'b0110 and a grant pending -> set_unoccupied=4'b0110, station_load=0, bus_asserted=0 next cycle.
- Reset asserted during a broadcast -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/station_scheduler.sv
// Reservation-station control: lowest-free allocation for issue, round-robin
// arbitration of the shared result bus, and a registered bus broadcast.
module station_scheduler #(
  parameter int SIZE               = 32,
  parameter int STATION_COUNT      = 4,
  parameter int STATION_INDEX_SIZE = $clog2(STATION_COUNT)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  output logic [STATION_INDEX_SIZE-1:0] issue_station,
  output logic [STATION_COUNT-1:0]      station_load,
  output logic [STATION_COUNT-1:0]      station_set_unoccupied,
  input  logic [STATION_COUNT-1:0]      station_occupied,
  input  logic [STATION_COUNT-1:0]      station_result_ready,
  input  logic [STATION_COUNT*SIZE-1:0] station_result,
  output logic                          bus_asserted,
  output logic [STATION_INDEX_SIZE-1:0] bus_source,
  output logic [SIZE-1:0]               bus_value
);

  localparam logic [STATION_INDEX_SIZE:0] COUNT_W = (STATION_INDEX_SIZE+1)'(STATION_COUNT);

  logic [STATION_COUNT-1:0]      free_s;
  logic [STATION_COUNT-1:0]      cand_s;
  logic                          alloc_found_s;
  logic [STATION_INDEX_SIZE-1:0] alloc_idx_s;
  logic                          grant_found_s;
  logic                          grant_valid_s;
  logic [STATION_INDEX_SIZE-1:0] grant_idx_s;
  logic [STATION_INDEX_SIZE:0]   sum_s;
  logic [STATION_INDEX_SIZE:0]   pos_s;
  logic [STATION_INDEX_SIZE-1:0] rr_next_s;
  logic [STATION_INDEX_SIZE-1:0] rr_ptr_r;

  assign free_s = ~station_occupied;
  assign cand_s = station_occupied & station_result_ready;

  // Lowest-index free station; descending scan lets the lowest index win.
  always_comb begin
    alloc_found_s = 1'b0;
    alloc_idx_s   = '0;
    for (int i = STATION_COUNT - 1; i >= 0; i--) begin
      alloc_found_s = free_s[i] ? 1'b1 : alloc_found_s;
      alloc_idx_s   = free_s[i] ? STATION_INDEX_SIZE'(i) : alloc_idx_s;
    end
  end

  // Round-robin search from rr_ptr_r upward; descending offset keeps the nearest candidate.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    sum_s         = '0;
    pos_s         = '0;
    for (int k = STATION_COUNT - 1; k >= 0; k--) begin
      sum_s = {1'b0, rr_ptr_r} + (STATION_INDEX_SIZE+1)'(k);
      pos_s = (sum_s >= COUNT_W) ? (sum_s - COUNT_W) : sum_s;
      grant_found_s = cand_s[pos_s[STATION_INDEX_SIZE-1:0]] ? 1'b1 : grant_found_s;
      grant_idx_s   = cand_s[pos_s[STATION_INDEX_SIZE-1:0]] ? pos_s[STATION_INDEX_SIZE-1:0]
                                                            : grant_idx_s;
    end
  end

  assign grant_valid_s = grant_found_s && !flush && !reset;
  assign rr_next_s = (grant_idx_s == STATION_INDEX_SIZE'(STATION_COUNT - 1))
                   ? '0 : grant_idx_s + STATION_INDEX_SIZE'(1);

  // Issue handshake and station strobes; reset beats flush beats issue/grant.
  always_comb begin
    issue_ready            = 1'b0;
    issue_station          = '0;
    station_load           = '0;
    station_set_unoccupied = '0;
    if (reset) begin
      issue_ready = 1'b0;
    end else if (flush) begin
      station_set_unoccupied = station_occupied;
    end else begin
      issue_ready   = alloc_found_s;
      issue_station = alloc_found_s ? alloc_idx_s : '0;
      if (issue_valid && alloc_found_s) begin
        station_load[alloc_idx_s] = 1'b1;
      end else begin
        station_load = '0;
      end
      if (grant_valid_s) begin
        station_set_unoccupied[grant_idx_s] = 1'b1;
      end else begin
        station_set_unoccupied = '0;
      end
    end
  end

  // Result bus register and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_asserted <= 1'b0;
      bus_source   <= '0;
      bus_value    <= '0;
      rr_ptr_r     <= '0;
    end else if (flush) begin
      bus_asserted <= 1'b0;
      rr_ptr_r     <= '0;
    end else if (grant_valid_s) begin
      bus_asserted <= 1'b1;
      bus_source   <= grant_idx_s;
      bus_value    <= station_result[grant_idx_s*SIZE +: SIZE];
      rr_ptr_r     <= rr_next_s;
    end else begin
      bus_asserted <= 1'b0;
    end
  end

endmodule
